dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 195 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// request-to-response latency and RISC-V load/store sizing.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (fault misaligned half/word
// accesses instead of performing them bytewise).
module dmem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [WIDTH-1:0] req_adr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  input  logic [2:0]       req_size_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t               state_r;
  logic [3:0]           cnt_r;
  logic                 we_r;
  logic [ADDR_BITS-1:0] adr_r;
  logic [WIDTH-1:0]     wdata_r;
  logic [2:0]           size_r;

  logic [7:0] mem [0:(2**ADDR_BITS)-1];

  // Access view: live inputs while idle (needed for LATENCY=1), latched otherwise
  logic                 acc_we_s;
  logic [ADDR_BITS-1:0] acc_adr_s;
  logic [WIDTH-1:0]     acc_wdata_s;
  logic [2:0]           acc_size_s;
  logic [ADDR_BITS-1:0] a0_s, a1_s, a2_s, a3_s;
  logic [3:0]           be_s;
  logic                 misalign_s;
  logic                 enter_resp_s;
  logic                 commit_s;
  logic [WIDTH-1:0]     load_s;
  logic [WIDTH-1:0]     rsp_data_s;

  // Select which request fields drive the memory access this cycle
  always_comb begin
    if (state_r == IDLE) begin
      acc_we_s    = req_we_i;
      acc_adr_s   = req_adr_i[ADDR_BITS-1:0];
      acc_wdata_s = req_wdata_i;
      acc_size_s  = req_size_i;
    end else begin
      acc_we_s    = we_r;
      acc_adr_s   = adr_r;
      acc_wdata_s = wdata_r;
      acc_size_s  = size_r;
    end
  end

  // Byte addresses wrap naturally at the ADDR_BITS boundary
  assign a0_s = acc_adr_s;
  assign a1_s = acc_adr_s + ADDR_BITS'(1);
  assign a2_s = acc_adr_s + ADDR_BITS'(2);
  assign a3_s = acc_adr_s + ADDR_BITS'(3);

  // Byte enables and load extension by funct3; illegal codes act as word
  always_comb begin
    load_s = '0;
    be_s   = 4'b1111;
    case (acc_size_s)
      3'b000: begin
        be_s   = 4'b0001;
        load_s = WIDTH'($signed(mem[a0_s]));
      end
      3'b001: begin
        be_s   = 4'b0011;
        load_s = WIDTH'($signed({mem[a1_s], mem[a0_s]}));
      end
      3'b100: begin
        be_s   = 4'b0001;
        load_s = WIDTH'(mem[a0_s]);
      end
      3'b101: begin
        be_s   = 4'b0011;
        load_s = WIDTH'({mem[a1_s], mem[a0_s]});
      end
      default: begin
        be_s   = 4'b1111;
        load_s = WIDTH'({mem[a3_s], mem[a2_s], mem[a1_s], mem[a0_s]});
      end
    endcase
  end

  // Alignment fault detection (half: adr[0], word: adr[1:0])
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    if (acc_size_s[1:0] == 2'b00) begin
      misalign_s = 1'b0;
    end else if (acc_size_s[1:0] == 2'b01) begin
      misalign_s = acc_adr_s[0];
    end else begin
      misalign_s = (acc_adr_s[1:0] != 2'b00);
    end
`else
    misalign_s = 1'b0;
`endif
  end

  // The edge that moves the FSM into RESP is the one that commits the access
  always_comb begin
    if (state_r == IDLE) begin
      enter_resp_s = req_valid_i && (LATENCY == 1);
    end else if (state_r == WAIT) begin
      enter_resp_s = (cnt_r <= 4'd1);
    end else begin
      enter_resp_s = 1'b0;
    end
  end

  assign commit_s   = enter_resp_s && acc_we_s && !misalign_s && !rst;
  assign rsp_data_s = (acc_we_s || misalign_s) ? '0 : load_s;

  // Store commit; memory is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (commit_s) begin
      if (be_s[0]) mem[a0_s] <= acc_wdata_s[7:0];
      if (be_s[1]) mem[a1_s] <= acc_wdata_s[15:8];
      if (be_s[2]) mem[a2_s] <= acc_wdata_s[23:16];
      if (be_s[3]) mem[a3_s] <= acc_wdata_s[31:24];
    end
  end

  // Request/latency/response FSM with registered handshake and data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      adr_r       <= '0;
      wdata_r     <= '0;
      size_r      <= 3'b000;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            we_r        <= req_we_i;
            adr_r       <= req_adr_i[ADDR_BITS-1:0];
            wdata_r     <= req_wdata_i;
            size_r      <= req_size_i;
            cnt_r       <= 4'(LATENCY - 1);
            req_ready_o <= 1'b0;
            if (enter_resp_s) begin
              state_r     <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rsp_data_s;
              rsp_err_o   <= misalign_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (enter_resp_s) begin
            cnt_r       <= 4'd0;
            state_r     <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rsp_data_s;
            rsp_err_o   <= misalign_s;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_r     <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2, ADDR_BITS=16).
// Expected responses are queued at request time and compared on response.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic [2:0]  req_size_i = 3'b010;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] mem_m [int];

  dmem_responder #(.WIDTH(32), .ADDR_BITS(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i),
    .req_size_i(req_size_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  // Reference byte model for the randomised traffic
  function automatic logic [7:0] m_byte(input int a);
    int k = a & 32'h0000FFFF;
    if (mem_m.exists(k)) return mem_m[k];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_load(input int a, input logic [2:0] sz);
    logic [7:0] b0 = m_byte(a);
    logic [7:0] b1 = m_byte(a + 1);
    logic [7:0] b2 = m_byte(a + 2);
    logic [7:0] b3 = m_byte(a + 3);
    case (sz)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic m_store(input int a, input logic [2:0] sz, input logic [31:0] wd);
    int n = (sz == 3'b000 || sz == 3'b100) ? 1 : (sz == 3'b001 || sz == 3'b101) ? 2 : 4;
    for (int i = 0; i < n; i++) mem_m[(a + i) & 32'h0000FFFF] = wd[8*i +: 8];
  endtask

  // Drive one request, check it is accepted, queue its expected response
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [2:0] sz, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_wdata_i = wd; req_size_i = sz;
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready adr=%h: got %b want 1", adr, req_ready_o);
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    req_we_i = 1'b0; req_wdata_i = 32'h0;
    e.d = exp_d; e.e = exp_e;
    sb_q.push_back(e);
  endtask

  // Wait for the response, check latency/data, optionally stall, then consume
  task automatic receive(input int hold);
    int   lat = 0;
    exp_t e;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_cmp++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d (0 = timeout)", lat, LAT);
    end
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    n_cmp++;
    if (rsp_rdata_o !== e.d) begin
      n_fail++;
      $display("FAIL rdata: got %h want %h", rsp_rdata_o, e.d);
    end
    n_cmp++;
    if (rsp_err_o !== e.e) begin
      n_fail++;
      $display("FAIL err: got %b want %b", rsp_err_o, e.e);
    end
    for (int h = 0; h < hold; h++) begin
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.d || req_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                 h, rsp_valid_o, rsp_rdata_o, req_ready_o, e.d);
      end
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
               req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
  endtask

  task automatic test_word();
    send(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);          receive(0);
    send(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);          receive(0);
  endtask

  task automatic test_sizes();
    send(1'b0, 32'h103, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);          receive(0);
    send(1'b0, 32'h103, 32'h0, 3'b100, 32'h000000DE, 1'b0);          receive(0);
    send(1'b0, 32'h100, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);          receive(0);
    send(1'b0, 32'h102, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);          receive(0);
    send(1'b0, 32'h100, 32'h0, 3'b011, 32'hDEADBEEF, 1'b0);          receive(0);
    send(1'b0, 32'h10100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);        receive(0);
    send(1'b1, 32'h101, 32'h000000A5, 3'b000, 32'h0, 1'b0);          receive(0);
    send(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADA5EF, 1'b0);          receive(0);
  endtask

  task automatic test_backpressure();
    send(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADA5EF, 1'b0);          receive(5);
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHECK_EN
    send(1'b0, 32'h102, 32'h0, 3'b010, 32'h0, 1'b1);                 receive(0);
    send(1'b1, 32'h102, 32'h55667788, 3'b010, 32'h0, 1'b1);          receive(0);
    send(1'b1, 32'h101, 32'h00007777, 3'b001, 32'h0, 1'b1);          receive(0);
    send(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADA5EF, 1'b0);          receive(0);
`else
    send(1'b1, 32'h0, 32'h0, 3'b010, 32'h0, 1'b0);                   receive(0);
    send(1'b1, 32'hFFFF, 32'h11223344, 3'b010, 32'h0, 1'b0);         receive(0);
    send(1'b0, 32'h0, 32'h0, 3'b010, 32'h00112233, 1'b0);            receive(0);
    send(1'b0, 32'hFFFF, 32'h0, 3'b010, 32'h11223344, 1'b0);         receive(0);
    send(1'b0, 32'hFFFF, 32'h0, 3'b001, 32'h00003344, 1'b0);         receive(0);
`endif
  endtask

  task automatic test_reset_mid();
    send(1'b1, 32'h200, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);          receive(0);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h200;
    req_wdata_i = 32'h12345678; req_size_i = 3'b010;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    req_we_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_state: got v=%b rdy=%b want v=0 rdy=1", rsp_valid_o, req_ready_o);
    end
    send(1'b0, 32'h200, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);          receive(0);
  endtask

  task automatic test_random();
    logic [2:0] sizes [5];
    sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b100; sizes[4] = 3'b101;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] wd = $urandom;
      send(1'b1, 32'h1000 + 32'(4 * i), wd, 3'b010, 32'h0, 1'b0);    receive(0);
      m_store(32'h1000 + 4 * i, 3'b010, wd);
    end
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  sz  = sizes[$urandom_range(0, 4)];
      logic        we  = 1'($urandom_range(0, 1));
      logic [31:0] wd  = $urandom;
      int          a   = 32'h1000 + int'($urandom_range(0, 31));
      if (sz == 3'b001 || sz == 3'b101) a = a & ~1;
      if (sz == 3'b010) a = a & ~3;
      if (we) begin
        send(1'b1, 32'(a), wd, sz, 32'h0, 1'b0);                     receive(0);
        m_store(a, sz, wd);
      end else begin
        send(1'b0, 32'(a), 32'h0, sz, m_load(a, sz), 1'b0);          receive(0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sizes();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
